// File: rtl/dsc_stoch2bin.sv
// Stochastic-to-binary converter for the DSC receive path.
// Counts ones in a serial bitstream over a window of 2^WIN_LOG2 enabled cycles.
// The result is held on a valid/ready handshake until the consumer accepts it.
module dsc_stoch2bin #(
    parameter int unsigned WIN_LOG2 = 24,
    parameter int unsigned OUT_W    = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             en,
    input  logic             sn_in,
    output logic [OUT_W-1:0] z,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             ov,
    output logic             busy
);

    // An all-ones window counts 2^WIN_LOG2, so one bit more than the window counter is needed.
    // The count is widened to OUT_W when OUT_W is larger, so z is a plain truncation.
    localparam int unsigned CNT_W = (WIN_LOG2 + 1 > OUT_W) ? WIN_LOG2 + 1 : OUT_W;
    localparam logic [CNT_W-1:0] CNT_SAT = {CNT_W{1'b1}} >> (CNT_W - OUT_W);
    localparam logic [WIN_LOG2-1:0] WIN_LAST = {WIN_LOG2{1'b1}};

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ACCUM = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    logic [1:0]          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [WIN_LOG2-1:0] win_q, win_d;
    logic [OUT_W-1:0]    z_q, z_d;
    logic                valid_q, valid_d;
    logic                ov_q, ov_d;
    logic                busy_q, busy_d;
    logic [CNT_W-1:0]    cnt_inc;

    // Saturating increment of the ones count by the current sample.
    always_comb begin
        cnt_inc = cnt_q;
        if (cnt_q != CNT_SAT) begin
            cnt_inc = cnt_q + CNT_W'(sn_in);
        end
    end

    // Next-state logic for the IDLE / ACCUM / HOLD controller.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        win_d   = win_q;
        z_d     = z_q;
        valid_d = valid_q;
        ov_d    = 1'b0;
        busy_d  = busy_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_ACCUM;
                    cnt_d   = '0;
                    win_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            ST_ACCUM: begin
                if (start) begin
                    // Abort: discard the partial window and this cycle's sample.
                    cnt_d = '0;
                    win_d = '0;
                end else if (en) begin
                    cnt_d = cnt_inc;
                    win_d = win_q + 1'b1;
                    if (win_q == WIN_LAST) begin
                        state_d = ST_HOLD;
                        z_d     = cnt_inc[OUT_W-1:0];
                        valid_d = 1'b1;
                        ov_d    = 1'b1;
                        busy_d  = 1'b0;
                    end
                end
            end
            ST_HOLD: begin
                // start is ignored here so a finished result is never dropped.
                if (out_ready) begin
                    state_d = ST_IDLE;
                    valid_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; async reset drops any partial window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            win_q   <= '0;
            z_q     <= '0;
            valid_q <= 1'b0;
            ov_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            win_q   <= win_d;
            z_q     <= z_d;
            valid_q <= valid_d;
            ov_q    <= ov_d;
            busy_q  <= busy_d;
        end
    end

    assign z         = z_q;
    assign out_valid = valid_q;
    assign ov        = ov_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_dsc_stoch2bin.sv
// Directed testbench for dsc_stoch2bin: a 16-cycle window with 8-bit and 4-bit results.
module tb_dsc_stoch2bin;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       en = 1'b0;
    logic       sn_in = 1'b0;
    logic       out_ready = 1'b0;
    logic [7:0] z;
    logic       out_valid, ov, busy;
    logic [3:0] z_s;
    logic       out_valid_s, ov_s, busy_s;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dsc_stoch2bin #(.WIN_LOG2(4), .OUT_W(8)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .en        (en),
        .sn_in     (sn_in),
        .z         (z),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ov        (ov),
        .busy      (busy)
    );

    dsc_stoch2bin #(.WIN_LOG2(4), .OUT_W(4)) u_sat (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .en        (en),
        .sn_in     (sn_in),
        .z         (z_s),
        .out_valid (out_valid_s),
        .out_ready (out_ready),
        .ov        (ov_s),
        .busy      (busy_s)
    );

    // Inputs set before this call are sampled on the coming edge; outputs are read 1 time unit later.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        en    = 1'b0;
        cycle();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        checks++;
        if (z !== 8'd0 || out_valid !== 1'b0 || ov !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: z=%0d valid=%b ov=%b busy=%b required 0/0/0/0",
                     z, out_valid, ov, busy);
        end
        cycle();
        rst_n = 1'b1;
        cycle();
    endtask

    task automatic test_all_ones();
        do_start();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL ones_busy: got %b required 1", busy);
        end
        for (int i = 0; i < 16; i++) begin
            en = 1'b1;
            sn_in = 1'b1;
            cycle();
            if (i == 14) begin
                checks++;
                if (out_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL ones_early_valid: got %b required 0", out_valid);
                end
            end
        end
        en = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || ov !== 1'b1 || z !== 8'd16 || busy !== 1'b0) begin
            errors++;
            $display("FAIL ones_done: valid=%b ov=%b z=%0d busy=%b required 1/1/16/0",
                     out_valid, ov, z, busy);
        end
        checks++;
        if (z_s !== 4'd15 || out_valid_s !== 1'b1) begin
            errors++;
            $display("FAIL ones_saturate: z=%0d valid=%b required 15/1", z_s, out_valid_s);
        end
        cycle();
        checks++;
        if (ov !== 1'b0 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL ones_ov_pulse: ov=%b valid=%b required 0/1", ov, out_valid);
        end
        for (int i = 0; i < 3; i++) cycle();
        checks++;
        if (out_valid !== 1'b1 || z !== 8'd16) begin
            errors++;
            $display("FAIL ones_held: valid=%b z=%0d required 1/16", out_valid, z);
        end
        out_ready = 1'b1;
        cycle();
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || z !== 8'd16) begin
            errors++;
            $display("FAIL ones_accept: valid=%b z=%0d required 0/16", out_valid, z);
        end
    endtask

    task automatic test_en_toggle();
        int ov_cnt = 0;
        int first_valid = -1;
        do_start();
        for (int c = 0; c < 36; c++) begin
            en = (c % 2 == 0) && (c < 32);
            sn_in = en ? (((c / 2) % 2) == 0) : 1'b1;
            cycle();
            if (ov === 1'b1) ov_cnt++;
            if (out_valid === 1'b1 && first_valid < 0) first_valid = c;
        end
        en = 1'b0;
        checks++;
        if (first_valid != 30) begin
            errors++;
            $display("FAIL toggle_latency: valid after cycle %0d required 30", first_valid);
        end
        checks++;
        if (z !== 8'd8) begin
            errors++;
            $display("FAIL toggle_z: got %0d required 8", z);
        end
        checks++;
        if (ov_cnt != 1) begin
            errors++;
            $display("FAIL toggle_ov_count: got %0d required 1", ov_cnt);
        end
        out_ready = 1'b1;
        cycle();
        out_ready = 1'b0;
    endtask

    task automatic test_abort();
        int ov_cnt = 0;
        int early_valid = 0;
        do_start();
        for (int i = 0; i < 5; i++) begin
            en = 1'b1;
            sn_in = 1'b1;
            cycle();
            if (ov === 1'b1) ov_cnt++;
        end
        start = 1'b1;
        en = 1'b1;
        sn_in = 1'b1;
        cycle();
        start = 1'b0;
        if (ov === 1'b1) ov_cnt++;
        for (int k = 0; k < 16; k++) begin
            en = 1'b1;
            sn_in = (k == 2 || k == 7 || k == 15);
            cycle();
            if (ov === 1'b1) ov_cnt++;
            if (k < 15 && out_valid === 1'b1) early_valid++;
        end
        en = 1'b0;
        checks++;
        if (early_valid != 0) begin
            errors++;
            $display("FAIL abort_early_valid: got %0d cycles required 0", early_valid);
        end
        checks++;
        if (z !== 8'd3 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL abort_z: z=%0d valid=%b required 3/1", z, out_valid);
        end
        checks++;
        if (ov_cnt != 1) begin
            errors++;
            $display("FAIL abort_ov_count: got %0d required 1", ov_cnt);
        end
        out_ready = 1'b1;
        cycle();
        out_ready = 1'b0;
    endtask

    task automatic test_hold();
        int bad = 0;
        do_start();
        for (int k = 0; k < 16; k++) begin
            en = 1'b1;
            sn_in = (k < 5);
            cycle();
        end
        checks++;
        if (z !== 8'd5 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL hold_z: z=%0d valid=%b required 5/1", z, out_valid);
        end
        for (int i = 0; i < 10; i++) begin
            start = (i == 4);
            en = 1'b1;
            sn_in = 1'b1;
            cycle();
            if (z !== 8'd5 || out_valid !== 1'b1 || busy !== 1'b0) bad++;
        end
        start = 1'b0;
        en = 1'b0;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL hold_stable: %0d unstable cycles required 0", bad);
        end
        out_ready = 1'b1;
        cycle();
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL hold_release: valid=%b busy=%b required 0/0", out_valid, busy);
        end
        do_start();
        for (int k = 0; k < 16; k++) begin
            en = 1'b1;
            sn_in = (k == 0 || k == 15);
            cycle();
        end
        en = 1'b0;
        checks++;
        if (z !== 8'd2 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL hold_next_window: z=%0d valid=%b required 2/1", z, out_valid);
        end
        out_ready = 1'b1;
        cycle();
        out_ready = 1'b0;
    endtask

    task automatic test_async_reset();
        do_start();
        for (int i = 0; i < 7; i++) begin
            en = 1'b1;
            sn_in = 1'b1;
            cycle();
        end
        en = 1'b0;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (z !== 8'd0 || out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: z=%0d valid=%b busy=%b required 0/0/0",
                     z, out_valid, busy);
        end
        cycle();
        rst_n = 1'b1;
        cycle();
        do_start();
        for (int k = 0; k < 16; k++) begin
            en = 1'b1;
            sn_in = 1'b0;
            cycle();
        end
        en = 1'b0;
        checks++;
        if (z !== 8'd0 || out_valid !== 1'b1 || ov !== 1'b1) begin
            errors++;
            $display("FAIL reset_zeros_window: z=%0d valid=%b ov=%b required 0/1/1",
                     z, out_valid, ov);
        end
        out_ready = 1'b1;
        cycle();
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        do_start();
        for (int k = 0; k < 16; k++) begin
            en = 1'b1;
            sn_in = 1'b1;
            cycle();
        end
        en = 1'b0;
        checks++;
        if (z !== 8'd16 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL b2b_first: z=%0d valid=%b required 16/1", z, out_valid);
        end
        start = 1'b1;
        cycle();
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_accept: valid=%b busy=%b required 0/0", out_valid, busy);
        end
        cycle();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_restart: busy=%b required 1", busy);
        end
        for (int k = 0; k < 16; k++) begin
            en = 1'b1;
            sn_in = (k % 2 == 1);
            cycle();
        end
        en = 1'b0;
        checks++;
        if (z !== 8'd8 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL b2b_second: z=%0d valid=%b required 8/1", z, out_valid);
        end
        cycle();
        out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_all_ones();
        test_en_toggle();
        test_abort();
        test_hold();
        test_async_reset();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
